// File: rtl/calc_entry_assembler.sv
// calc_entry_assembler
// Turns keyboard-decoder key events into a calculation request
// (operand A, operator, operand B) and offers it to the link side.
// The value under edit is driven on `display`.
//
// Optional build macro: CALC_CHAIN_EN
//   When defined, adds respValid/respResult. After a transfer the block
//   waits in WAIT_RESP for the result, which becomes operand A so that a
//   following operator key chains a new calculation onto it.
//
// Handshake: reqValid is high for as long as a request is pending and the
// operands/operator are frozen during that time. A transfer happens at a
// clk edge where reqValid=1 and reqReady=1. reqReady is ignored while
// reqValid=0. A clear event on that same edge wins, and no transfer occurs.
module calc_entry_assembler #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       num,
  input  logic             numPressed,
  input  logic [1:0]       opt,
  input  logic             optPressed,
  input  logic             clear,
  input  logic             submit,
`ifdef CALC_CHAIN_EN
  input  logic             respValid,
  input  logic [WIDTH-1:0] respResult,
`endif
  output logic [WIDTH-1:0] operandA,
  output logic [WIDTH-1:0] operandB,
  output logic [1:0]       operator,
  output logic             reqValid,
  input  logic             reqReady,
  output logic [WIDTH-1:0] display,
  output logic [1:0]       entryState
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(DIGITS);

  typedef enum logic [1:0] {
    ENTER_A   = 2'd0,
    ENTER_B   = 2'd1,
    REQUEST   = 2'd2,
    WAIT_RESP = 2'd3
  } state_e;

  // Architectural state
  state_e           state_q,   state_d;
  logic [WIDTH-1:0] op_a_q,    op_a_d;
  logic [WIDTH-1:0] op_b_q,    op_b_d;
  logic [1:0]       oper_q,    oper_d;
  logic [CW-1:0]    cnt_a_q,   cnt_a_d;
  logic [CW-1:0]    cnt_b_q,   cnt_b_d;

  // Previous key levels for rising-edge detection
  logic             num_prev_q;
  logic             opt_prev_q;
  logic             clr_prev_q;
  logic             sub_prev_q;

  // Raw rising-level events
  logic             num_rise;
  logic             opt_rise;
  logic             clr_rise;
  logic             sub_rise;

  // Prioritised events: at most one of these is high in any cycle
  logic             ev_clr;
  logic             ev_sub;
  logic             ev_opt;
  logic             ev_num;

  // Qualifiers shared by both operand-entry states
  logic             digit_ok;
  logic             opt_ok;

  // Shift a decimal digit into an operand. The product is formed four bits
  // wider than the operand and then truncated; with 10^DIGITS-1 fitting in
  // WIDTH and the digit-count limit, nothing is ever lost.
  function automatic logic [WIDTH-1:0] append_digit(
    input logic [WIDTH-1:0] value,
    input logic [3:0]       digit
  );
    return WIDTH'(({4'b0000, value} * (WIDTH + 4)'(10)) +
                  {{WIDTH{1'b0}}, digit});
  endfunction

  // Rising-level detection and clear > submit > opt > num priority
  always_comb begin
    num_rise = numPressed & ~num_prev_q;
    opt_rise = optPressed & ~opt_prev_q;
    clr_rise = clear      & ~clr_prev_q;
    sub_rise = submit     & ~sub_prev_q;

    ev_clr = clr_rise;
    ev_sub = sub_rise & ~clr_rise;
    ev_opt = opt_rise & ~clr_rise & ~sub_rise;
    ev_num = num_rise & ~clr_rise & ~sub_rise & ~opt_rise;

    // Codes above 9 are never digits, and only add/sub are operators
    digit_ok = (num <= 4'd9);
    opt_ok   = (opt == 2'd1) || (opt == 2'd2);
  end

  // Next-state logic for the entry FSM and the operand datapath
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    oper_d  = oper_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;

    if (ev_clr) begin
      // Clear aborts everything, including a pending request
      state_d = ENTER_A;
      op_a_d  = '0;
      op_b_d  = '0;
      oper_d  = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
    end else begin
      unique case (state_q)
        ENTER_A: begin
          if (ev_sub) begin
            // Nothing to submit yet; the event is consumed and dropped
            state_d = ENTER_A;
          end else if (ev_opt) begin
            if (opt_ok) begin
              oper_d  = opt;
              state_d = ENTER_B;
            end
          end else if (ev_num) begin
            if (digit_ok && (cnt_a_q < MAX_CNT)) begin
              op_a_d  = append_digit(op_a_q, num);
              cnt_a_d = cnt_a_q + CW'(1);
            end
          end
        end

        ENTER_B: begin
          if (ev_sub) begin
            // A request needs at least one digit in operand B
            if (cnt_b_q != '0) begin
              state_d = REQUEST;
            end
          end else if (ev_opt) begin
            // The operator may be corrected only until B has a digit
            if (opt_ok && (cnt_b_q == '0)) begin
              oper_d = opt;
            end
          end else if (ev_num) begin
            if (digit_ok && (cnt_b_q < MAX_CNT)) begin
              op_b_d  = append_digit(op_b_q, num);
              cnt_b_d = cnt_b_q + CW'(1);
            end
          end
        end

        REQUEST: begin
          // Operands are frozen; only the link side can move us on
          if (reqReady) begin
            op_a_d  = '0;
            op_b_d  = '0;
            oper_d  = '0;
            cnt_a_d = '0;
            cnt_b_d = '0;
`ifdef CALC_CHAIN_EN
            state_d = WAIT_RESP;
`else
            state_d = ENTER_A;
`endif
          end
        end

`ifdef CALC_CHAIN_EN
        WAIT_RESP: begin
          // The result becomes a full-length operand A so no digits append
          if (respValid) begin
            op_a_d  = respResult;
            cnt_a_d = MAX_CNT;
            state_d = ENTER_A;
          end
        end
`endif

        default: begin
          state_d = ENTER_A;
        end
      endcase
    end
  end

  // State, datapath and edge-history registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ENTER_A;
      op_a_q     <= '0;
      op_b_q     <= '0;
      oper_q     <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      num_prev_q <= 1'b0;
      opt_prev_q <= 1'b0;
      clr_prev_q <= 1'b0;
      sub_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      oper_q     <= oper_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      num_prev_q <= numPressed;
      opt_prev_q <= optPressed;
      clr_prev_q <= clear;
      sub_prev_q <= submit;
    end
  end

  // Output decode; every output comes straight from registered state
  always_comb begin
    operandA   = op_a_q;
    operandB   = op_b_q;
    operator   = oper_q;
    reqValid   = (state_q == REQUEST);
    entryState = state_q;
    if ((state_q == ENTER_B) || (state_q == REQUEST)) begin
      display = op_b_q;
    end else begin
      display = op_a_q;
    end
  end

endmodule

// File: tb/tb_calc_entry_assembler.sv
// Directed bench for calc_entry_assembler (default build).
// Stimulus pushes each expected request {A, B, op} into exp_q; a monitor
// pops and compares whenever the DUT completes a handshake. State-level
// expectations are checked inline against hand-computed constants.
module tb_calc_entry_assembler;

  localparam int WIDTH = 14;
  localparam int RW    = 2 * WIDTH + 2;

  logic             clk;
  logic             reset;
  logic [3:0]       num;
  logic             numPressed;
  logic [1:0]       opt;
  logic             optPressed;
  logic             clear;
  logic             submit;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic [1:0]       operator;
  logic             reqValid;
  logic             reqReady;
  logic [WIDTH-1:0] display;
  logic [1:0]       entryState;

  int total = 0;
  int bad   = 0;

  logic [RW-1:0] exp_q[$];

  calc_entry_assembler #(.DIGITS(4), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .num        (num),
    .numPressed (numPressed),
    .opt        (opt),
    .optPressed (optPressed),
    .clear      (clear),
    .submit     (submit),
    .operandA   (operandA),
    .operandB   (operandB),
    .operator   (operator),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .display    (display),
    .entryState (entryState)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers / drivers ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_num(input logic [3:0] d);
    num = d; numPressed = 1'b1; tick(5);
    numPressed = 1'b0; tick(5);
  endtask

  task automatic press_opt(input logic [1:0] o);
    opt = o; optPressed = 1'b1; tick(5);
    optPressed = 1'b0; tick(5);
  endtask

  task automatic press_sub();
    submit = 1'b1; tick(5);
    submit = 1'b0; tick(5);
  endtask

  task automatic press_clr();
    clear = 1'b1; tick(5);
    clear = 1'b0; tick(5);
  endtask

  // ---------------- scoreboard monitor ----------------
  // A handshake seen at the falling edge completes at the next rising edge,
  // unless a clear is being raised in the same cycle (clear wins).
  always @(negedge clk) begin
    if (reset && reqValid && reqReady && !clear) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL xfer_unexpected: got A=%0d B=%0d op=%0d expected none",
                 operandA, operandB, operator);
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        if ({operandA, operandB, operator} != e) begin
          bad++;
          $display("FAIL xfer: got A=%0d B=%0d op=%0d expected A=%0d B=%0d op=%0d",
                   operandA, operandB, operator,
                   e[RW-1 -: WIDTH], e[WIDTH+1 -: WIDTH], e[1:0]);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; num = '0; numPressed = 1'b0; opt = '0; optPressed = 1'b0;
    clear = 1'b0; submit = 1'b0; reqReady = 1'b0;

    // Reset held low for 3 cycles
    tick(3);
    check("rst_a",     operandA,   0);
    check("rst_b",     operandB,   0);
    check("rst_op",    operator,   0);
    check("rst_valid", reqValid,   0);
    check("rst_disp",  display,    0);
    check("rst_state", entryState, 0);
    reset = 1'b1;
    tick(2);

    // Basic request 123 + 45
    press_num(4'd1); press_num(4'd2); press_num(4'd3);
    check("a_123_disp", display, 123);
    press_opt(2'd1);
    check("enter_b_state", entryState, 1);
    check("enter_b_op",    operator,   1);
    press_num(4'd4); press_num(4'd5);
    check("b_45_disp", display, 45);
    exp_q.push_back({14'd123, 14'd45, 2'd1});
    submit = 1'b1;
    tick(1);
    check("sub_valid_rise", reqValid, 1);
    check("sub_state",      entryState, 2);
    tick(3);
    submit = 1'b0;
    tick(1);
    check("hold_valid", reqValid, 1);
    check("hold_a",     operandA, 123);
    check("hold_b",     operandB, 45);
    check("hold_op",    operator, 1);
    reqReady = 1'b1;
    tick(1);
    reqReady = 1'b0;
    check("post_xfer_valid", reqValid,   0);
    check("post_xfer_a",     operandA,   0);
    check("post_xfer_b",     operandB,   0);
    check("post_xfer_op",    operator,   0);
    check("post_xfer_state", entryState, 0);
    tick(3);

    // Digit limit: fifth digit ignored
    press_num(4'd9); press_num(4'd8); press_num(4'd7); press_num(4'd6);
    press_num(4'd5);
    check("limit_a",    operandA, 9876);
    check("limit_disp", display,  9876);
    press_clr();
    check("clr_a", operandA, 0);

    // Held key yields one event; toggling num while held does nothing
    num = 4'd7; numPressed = 1'b1;
    tick(10);
    num = 4'd3;
    tick(30);
    check("held_a", operandA, 7);
    numPressed = 1'b0; tick(5);
    check("held_release_a", operandA, 7);
    press_clr();

    // Non-digit codes and invalid operators are ignored
    press_num(4'd4);
    press_num(4'd12);
    check("nondigit_a", operandA, 4);
    press_opt(2'd0);
    check("opt0_state", entryState, 0);
    press_opt(2'd3);
    check("opt3_state", entryState, 0);
    press_clr();

    // Submit with no B digits, operator correction, then late opt ignored
    press_num(4'd1);
    press_opt(2'd2);
    check("opt2_op", operator, 2);
    press_sub();
    check("empty_b_state", entryState, 1);
    check("empty_b_valid", reqValid,   0);
    press_opt(2'd1);
    check("opt_replace", operator, 1);
    press_num(4'd3);
    press_opt(2'd2);
    check("opt_locked",   operator, 1);
    check("opt_locked_d", display,  3);
    press_sub();
    check("req2_valid", reqValid, 1);
    check("req2_a",     operandA, 1);
    check("req2_b",     operandB, 3);
    // Frozen in REQUEST: digits ignored
    press_num(4'd8);
    check("frozen_b", operandB, 3);

    // Clear on the same edge as reqReady: abort, no transfer
    clear = 1'b1; reqReady = 1'b1;
    tick(1);
    reqReady = 1'b0;
    check("abort_valid", reqValid,   0);
    check("abort_a",     operandA,   0);
    check("abort_b",     operandB,   0);
    check("abort_state", entryState, 0);
    tick(4);
    clear = 1'b0;
    tick(3);

    // Zero-digit operand A is legal: 0 - 7
    press_opt(2'd2);
    press_num(4'd7);
    exp_q.push_back({14'd0, 14'd7, 2'd2});
    press_sub();
    reqReady = 1'b1;
    tick(1);
    reqReady = 1'b0;
    check("zero_a_state", entryState, 0);
    tick(3);

    // reqReady outside REQUEST has no effect
    press_num(4'd2);
    reqReady = 1'b1;
    tick(3);
    reqReady = 1'b0;
    check("stray_ready_a", operandA, 2);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
